// File: rtl/axrm_pkg.sv
// Shared types and default widths for the approximate-multiplier error accumulator.
package axrm_pkg;

    localparam int AXRM_N_W   = 8;
    localparam int AXRM_ACC_W = 32;
    localparam int AXRM_CNT_W = 17;

    typedef enum logic [1:0] {
        ACC_IDLE  = 2'd0,
        ACC_RUN   = 2'd1,
        ACC_DRAIN = 2'd2,
        ACC_DONE  = 2'd3
    } axrm_acc_state_t;

endpackage

// File: rtl/axrm_ed_unit.sv
// Error distance |x - y| of two unsigned values; purely combinational, zero latency.
// No handshake: the enclosing pipeline stage qualifies the result.
module axrm_ed_unit #(
    parameter int W = 16
) (
    input  logic [W-1:0] x,
    input  logic [W-1:0] y,
    output logic [W-1:0] ed
);

    assign ed = (x >= y) ? (x - y) : (y - x);

endmodule

// File: rtl/axrm_err_accum.sv
// Session error statistics (count, errors, ED sum/max) for an approximate multiplier; stats lag accept by 1 edge.
// Backpressure: in_ready only while a session is running; DRAIN and DONE refuse samples until the next start.
module axrm_err_accum
    import axrm_pkg::*;
#(
    parameter int N_W   = AXRM_N_W,
    parameter int ACC_W = AXRM_ACC_W,
    parameter int CNT_W = AXRM_CNT_W
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic               in_last,
    input  logic [N_W-1:0]     a,
    input  logic [N_W-1:0]     b,
    input  logic [2*N_W-1:0]   approx,
    output logic               busy,
    output logic               done,
    output logic [CNT_W-1:0]   sample_count,
    output logic [CNT_W-1:0]   err_count,
    output logic [ACC_W-1:0]   ed_sum,
    output logic [2*N_W-1:0]   ed_max,
    output logic               sat
);

    localparam int P_W = 2 * N_W;
    // Sum is widened past both operands so a single compare detects overflow for any ACC_W.
    localparam int S_W = ((ACC_W > P_W) ? ACC_W : P_W) + 1;

    axrm_acc_state_t state, state_nxt;

    logic           accept;
    logic           clear;
    logic           s1_vld;
    logic [P_W-1:0] s1_exact;
    logic [P_W-1:0] s1_approx;
    logic [P_W-1:0] ed;

    logic [CNT_W:0] cnt_wide;
    logic [CNT_W:0] err_wide;
    logic [S_W-1:0] sum_wide;
    logic           cnt_ovf;
    logic           err_ovf;
    logic           sum_ovf;

    assign in_ready = (state == ACC_RUN);
    assign busy     = (state == ACC_RUN) || (state == ACC_DRAIN);
    assign done     = (state == ACC_DONE);
    assign accept   = in_valid && in_ready;
    assign clear    = start && ((state == ACC_IDLE) || (state == ACC_DONE));

    always_comb begin
        state_nxt = state;
        case (state)
            ACC_IDLE:  if (start)                state_nxt = ACC_RUN;
            ACC_RUN:   if (accept && in_last)    state_nxt = ACC_DRAIN;
            ACC_DRAIN: if (!s1_vld)              state_nxt = ACC_DONE;
            ACC_DONE:  if (start)                state_nxt = ACC_RUN;
            default:                             state_nxt = ACC_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ACC_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_vld    <= 1'b0;
            s1_exact  <= '0;
            s1_approx <= '0;
        end else if (clear) begin
            s1_vld    <= 1'b0;
        end else begin
            s1_vld <= accept;
            if (accept) begin
                s1_exact  <= P_W'(a) * P_W'(b);
                s1_approx <= approx;
            end
        end
    end

    axrm_ed_unit #(
        .W (P_W)
    ) u_ed (
        .x  (s1_exact),
        .y  (s1_approx),
        .ed (ed)
    );

    assign cnt_wide = {1'b0, sample_count} + (CNT_W + 1)'(1);
    assign err_wide = {1'b0, err_count} + (CNT_W + 1)'(ed != '0);
    assign sum_wide = S_W'(ed_sum) + S_W'(ed);
    assign cnt_ovf  = cnt_wide[CNT_W];
    assign err_ovf  = err_wide[CNT_W];
    assign sum_ovf  = sum_wide > S_W'({ACC_W{1'b1}});

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sample_count <= '0;
            err_count    <= '0;
            ed_sum       <= '0;
            ed_max       <= '0;
            sat          <= 1'b0;
        end else if (clear) begin
            sample_count <= '0;
            err_count    <= '0;
            ed_sum       <= '0;
            ed_max       <= '0;
            sat          <= 1'b0;
        end else if (s1_vld) begin
            sample_count <= cnt_ovf ? {CNT_W{1'b1}} : cnt_wide[CNT_W-1:0];
            err_count    <= err_ovf ? {CNT_W{1'b1}} : err_wide[CNT_W-1:0];
            ed_sum       <= sum_ovf ? {ACC_W{1'b1}} : sum_wide[ACC_W-1:0];
            ed_max       <= (ed > ed_max) ? ed : ed_max;
            sat          <= sat | cnt_ovf | err_ovf | sum_ovf;
        end
    end

endmodule

// File: tb/tb_axrm_err_accum.sv
// Directed + randomized bench for axrm_err_accum; two instances (32-bit and 8-bit ED sum) share stimulus.
module tb_axrm_err_accum;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic        in_valid;
    logic        in_last;
    logic [7:0]  a;
    logic [7:0]  b;
    logic [15:0] approx;

    logic        in_ready, busy, done, sat;
    logic [16:0] sample_count, err_count;
    logic [31:0] ed_sum;
    logic [15:0] ed_max;

    logic        s_in_ready, s_busy, s_done, s_sat;
    logic [16:0] s_sample_count, s_err_count;
    logic [7:0]  s_ed_sum;
    logic [15:0] s_ed_max;

    int checks = 0;
    int errors = 0;

    logic [7:0]  qa[$];
    logic [7:0]  qb[$];
    logic [15:0] qp[$];

    axrm_err_accum dut (
        .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid), .in_ready(in_ready),
        .in_last(in_last), .a(a), .b(b), .approx(approx), .busy(busy), .done(done),
        .sample_count(sample_count), .err_count(err_count), .ed_sum(ed_sum),
        .ed_max(ed_max), .sat(sat)
    );

    axrm_err_accum #(.ACC_W(8)) dut_s (
        .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid), .in_ready(s_in_ready),
        .in_last(in_last), .a(a), .b(b), .approx(approx), .busy(s_busy), .done(s_done),
        .sample_count(s_sample_count), .err_count(s_err_count), .ed_sum(s_ed_sum),
        .ed_max(s_ed_max), .sat(s_sat)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic add(input int va, input int vb, input int vp);
        qa.push_back(8'(va));
        qb.push_back(8'(vb));
        qp.push_back(16'(vp));
    endtask

    task automatic clear_q();
        qa.delete();
        qb.delete();
        qp.delete();
    endtask

    // Statistics straight from the definition: products, absolute differences, clamp at the end.
    task automatic model(input int accw, output longint cnt, output longint errs,
                         output longint sum, output longint mx, output bit sat_e);
        longint lim;
        longint cnt_lim;
        longint exact, ed;
        lim     = (longint'(1) << accw) - 1;
        cnt_lim = (longint'(1) << 17) - 1;
        cnt = 0; errs = 0; sum = 0; mx = 0; sat_e = 0;
        foreach (qa[i]) begin
            exact = longint'(qa[i]) * longint'(qb[i]);
            ed    = (exact >= longint'(qp[i])) ? exact - longint'(qp[i]) : longint'(qp[i]) - exact;
            cnt++;
            if (ed != 0) errs++;
            sum += ed;
            if (ed > mx) mx = ed;
        end
        if (sum > lim)      begin sum  = lim;     sat_e = 1; end
        if (cnt > cnt_lim)  begin cnt  = cnt_lim; sat_e = 1; end
        if (errs > cnt_lim) begin errs = cnt_lim; sat_e = 1; end
    endtask

    task automatic check_final();
        longint cnt, errs, sum, mx;
        bit     sat_e;
        model(32, cnt, errs, sum, mx, sat_e);
        check("cnt",     sample_count, cnt);
        check("errs",    err_count,    errs);
        check("sum",     ed_sum,       sum);
        check("max",     ed_max,       mx);
        check("sat",     sat,          sat_e);
        model(8, cnt, errs, sum, mx, sat_e);
        check("s_cnt",   s_sample_count, cnt);
        check("s_errs",  s_err_count,    errs);
        check("s_sum",   s_ed_sum,       sum);
        check("s_max",   s_ed_max,       mx);
        check("s_sat",   s_sat,          sat_e);
    endtask

    // Drives the queued samples as one session, checking handshake, latency and drain timing.
    task automatic run_session(input int gap_pct, input bit noise);
        int n;
        int guard;
        n = qa.size();
        start = 1'b1;
        tick();
        start = 1'b0;
        check("start_busy",  busy,         1);
        check("start_done",  done,         0);
        check("start_cnt",   sample_count, 0);
        check("start_ssum",  s_ed_sum,     0);
        check("start_sat",   sat,          0);
        for (int i = 0; i < n; i++) begin
            guard = 0;
            while (gap_pct > 0 && guard < 4 && $urandom_range(0, 99) < gap_pct) begin
                in_valid = 1'b0;
                in_last  = 1'($urandom_range(0, 1));
                start    = noise && ($urandom_range(0, 1) == 1);
                a        = 8'($urandom);
                b        = 8'($urandom);
                approx   = 16'($urandom);
                tick();
                guard++;
            end
            in_valid = 1'b1;
            in_last  = (i == n - 1);
            a        = qa[i];
            b        = qb[i];
            approx   = qp[i];
            start    = noise && ($urandom_range(0, 1) == 1);
            check("in_ready", in_ready, 1);
            tick();
            check("live_cnt", sample_count, i);
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
        start    = noise && ($urandom_range(0, 1) == 1);
        check("drain_busy",  busy,     1);
        check("drain_ready", in_ready, 0);
        check("drain_done",  done,     0);
        tick();
        start = 1'b0;
        check("acc_busy", busy,         1);
        check("acc_done", done,         0);
        check("acc_cnt",  sample_count, n);
        tick();
        check("done",      done, 1);
        check("done_busy", busy, 0);
        check_final();
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_ready"}, in_ready,     0);
        check({tag, "_busy"},  busy,         0);
        check({tag, "_done"},  done,         0);
        check({tag, "_sat"},   sat,          0);
        check({tag, "_cnt"},   sample_count, 0);
        check({tag, "_errs"},  err_count,    0);
        check({tag, "_sum"},   ed_sum,       0);
        check({tag, "_max"},   ed_max,       0);
        check({tag, "_ssum"},  s_ed_sum,     0);
        check({tag, "_ssat"},  s_sat,        0);
    endtask

    initial begin
        int n;
        int ex;
        rst_n = 1'b0; start = 1'b0; in_valid = 1'b0; in_last = 1'b0;
        a = '0; b = '0; approx = '0;
        tick();
        tick();
        check_zero("rst");
        rst_n = 1'b1;
        tick();
        tick();
        check_zero("idle");

        // single exact sample
        clear_q();
        add(255, 255, 65025);
        run_session(0, 1'b0);
        check("one_errs", err_count, 0);

        // three samples, back-to-back from DONE
        clear_q();
        add(3, 3, 7); add(10, 10, 100); add(255, 255, 64000);
        run_session(0, 1'b0);
        check("three_cnt",  sample_count, 3);
        check("three_errs", err_count,    2);
        check("three_sum",  ed_sum,       1027);
        check("three_max",  ed_max,       1025);

        // same samples with valid gaps and ignored start pulses
        run_session(60, 1'b1);
        check("gap_sum", ed_sum, 1027);

        // 8-bit sum saturates at 255 while the 32-bit instance does not
        clear_q();
        add(10, 10, 300); add(10, 10, 300);
        run_session(0, 1'b0);
        check("satsum_s",  s_ed_sum, 255);
        check("satflag_s", s_sat,    1);
        check("satmax_s",  s_ed_max, 200);
        check("satsum",    ed_sum,   400);

        // randomized sessions
        for (int s = 0; s < 20; s++) begin
            clear_q();
            n = $urandom_range(1, 40);
            for (int i = 0; i < n; i++) begin
                a = 8'($urandom);
                b = 8'($urandom);
                ex = int'(a) * int'(b);
                case ($urandom_range(0, 2))
                    0:       add(a, b, ex);
                    1:       add(a, b, ex + $urandom_range(0, 16) - 8);
                    default: add(a, b, $urandom_range(0, 65535));
                endcase
            end
            run_session($urandom_range(0, 50), 1'($urandom_range(0, 1)));
        end

        // reset in the middle of a session
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 2; i++) begin
            in_valid = 1'b1; in_last = 1'b0; a = 8'(7 + i); b = 8'(9); approx = 16'd1;
            tick();
        end
        in_valid = 1'b0;
        tick();
        check("mid_cnt", sample_count, 2);
        rst_n = 1'b0;
        #1;
        check_zero("midrst");
        tick();
        rst_n = 1'b1;
        tick();
        check_zero("postrst");
        clear_q();
        add(12, 34, 408);
        run_session(0, 1'b0);
        check("post_cnt", sample_count, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/axrm_err_accum.md
# axrm_err_accum

Pipelined error-statistics accumulator placed directly downstream of the 8x8 approximate recursive multipliers. Each accepted sample carries operands `a`, `b` and the multiplier's 16-bit `approx` product. The block computes the exact product and the error distance ED = |a*b − approx|, then accumulates sample count, erroneous-sample count, ED sum and ED maximum over a session delimited by `start` and `in_last`. It is the hardware error-evaluation stage used to characterise each approximate multiplier variant.

## Interface
Parameters:
- `N_W`, 8: operand width; product width is 2*N_W.
- `ACC_W`, 32: width of `ed_sum`; saturating.
- `CNT_W`, 17: width of `sample_count` and `err_count`; saturating.

Ports:
- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  one-cycle pulse; clears statistics and opens a session.
- `in_valid`  in  1  sample valid.
- `in_ready`  out  1  block accepts a sample.
- `in_last`  in  1  qualifies the final sample of the session.
- `a`  in  N_W  operand A.
- `b`  in  N_W  operand B.
- `approx`  in  2*N_W  approximate product under test.
- `busy`  out  1  high in RUN or DRAIN.
- `done`  out  1  high in DONE.
- `sample_count`  out  CNT_W  samples accumulated.
- `err_count`  out  CNT_W  samples with ED ≠ 0.
- `ed_sum`  out  ACC_W  sum of ED.
- `ed_max`  out  2*N_W  largest ED seen.
- `sat`  out  1  sticky; set when any counter or `ed_sum` saturates.

## Operation
- FSM states: IDLE, RUN, DRAIN, DONE.
  - IDLE→RUN on `start`.
  - RUN→DRAIN on an accepted sample with `in_last`=1.
  - DRAIN→DONE once the pipeline is empty.
  - DONE→RUN on `start`.
  - `start` is ignored in RUN and DRAIN.
- `in_ready` = (state == RUN). Accept occurs on a clock edge with `in_valid` && `in_ready`. `in_valid` gaps are allowed.
- `start` in IDLE or DONE zeroes all statistics, `sat` and the pipeline valid bits on the same edge.
- Stage 1 (edge of accept) registers the exact product `a*b` (unsigned, 2*N_W bits), `approx` and a valid bit.
- Stage 2 (next edge), when the stage-1 valid bit is set:
  - ED = |exact − approx|, 2*N_W bits unsigned.
  - `sample_count` += 1.
  - `err_count` += (ED ≠ 0).
  - `ed_sum` += ED.
  - `ed_max` = max(`ed_max`, ED).
- Saturation: an update that would overflow holds the field at all-ones and sets `sat`. `sat` remains set until `start` or reset.
- Statistic outputs are live during RUN and stable in DONE.

## Timing
- Reset values: state IDLE; `in_ready`, `busy`, `done`, `sat` = 0; all statistics = 0; pipeline valid bits = 0.
- Latency: a sample accepted at edge k is reflected in the statistics after edge k+1.
- Last sample accepted at edge k:
  - state is DRAIN after edge k;
  - final accumulation happens at edge k+1;
  - state is DONE and `done`=1 after edge k+2.
- Throughput: one sample per cycle while `in_valid` is held high.
- `in_last` with `in_valid`=0 has no effect.
- A `start` pulse on the same edge a DONE session ends clears the statistics. `done` drops after that edge.
- Asserting `rst_n` low mid-session immediately returns the block to the reset values. No partial statistics are retained.

## Structure
- `axrm_pkg` holds:
  - the FSM state enum `axrm_acc_state_t`;
  - the default widths `AXRM_N_W`=8, `AXRM_ACC_W`=32, `AXRM_CNT_W`=17.
- Sub-module `axrm_ed_unit`: purely combinational absolute difference of two 2*N_W-bit values. It is instantiated once, in stage 2.
- The exact multiply is inferred in stage 1. No approximate multiplier is instantiated inside this block.

## Test plan
- Reset: hold `rst_n` low, then release → all outputs 0 and state IDLE; `in_ready`=0 until `start`.
- Single exact sample: `start`; then a=255, b=255, approx=65025, `in_last`=1 → after 3 edges `done`=1, `sample_count`=1, `err_count`=0, `ed_sum`=0, `ed_max`=0.
- Three-sample session:
  - samples (3, 3, 7), (10, 10, 100), (255, 255, 64000);
  - →`sample_count`=3, `err_count`=2, `ed_sum`=1027, `ed_max`=1025, `sat`=0.
- Throughput and control:
  - `in_valid` gaps, plus a `start` pulse during RUN, over the same three samples → identical statistics; `start` ignored.
  - Back-to-back session from DONE → statistics cleared before accumulation.
- Saturation with ACC_W=8: two samples each with ED=200 → `ed_sum`=255, `sat`=1, `ed_max`=200.
- Reset mid-session: drop `rst_n` after 2 accepted samples → all outputs 0; a new `start` followed by one exact sample gives `sample_count`=1.
